// File: rtl/clock_div_mon.sv
// -----------------------------------------------------------------------------
// clock_div_mon
//
// Measures a divided clock (mon_in) against the ratio it is supposed to have.
// mon_in is treated purely as data: it is synchronised into the clk domain,
// edge-detected, and the clk cycles of one full period and of its high phase
// are counted. The result is compared against the expected ratio N_exp that
// was latched when the measurement was armed.
//
// Parameters
//   SIZE   width of N_exp (matches the divider's N width), must be >= 2
//   CNT_W  width of the measurement counter and results
//
// Ports
//   clk          sampling clock (the divider's source clock)
//   reset_n      asynchronous active-low reset
//   mon_in       divided clock under test, asynchronous to clk
//   N_exp        expected divide ratio, latched at arm time
//   enable       1 runs measurements, 0 aborts and idles
//   meas_ack     consumer acknowledge, only acted on while meas_valid=1
//   meas_valid   result registers valid, held until acknowledged
//   meas_period  clk cycles between successive mon_in rising edges
//   meas_high    clk cycles from mon_in rising to falling edge
//   mismatch     result disagrees with the latched ratio
//   timeout      no qualifying edge seen within the counter range
//   bypass       N_exp is 0 or 1: the divider passes clk straight through,
//                which this monitor cannot resolve
// -----------------------------------------------------------------------------
module clock_div_mon #(
    parameter int SIZE  = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mon_in,
    input  logic [SIZE-1:0]  N_exp,
    input  logic             enable,
    input  logic             meas_ack,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             mismatch,
    output logic             timeout,
    output logic             bypass
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    // Comparison width wide enough for both the ratio and the counter, plus a
    // spare bit so the ceil() rounding of the ratio cannot overflow.
    localparam int CMP_W = ((SIZE > CNT_W) ? SIZE : CNT_W) + 1;

    state_t           state;
    logic             s1, s2, q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_cap;
    logic [SIZE-1:0]  n_lat;

    logic rise;
    logic fall;
    logic n_measurable;

    // Edge detection on the synchronised copy; q is the previous value of s2.
    assign rise = s2 & ~q;
    assign fall = ~s2 & q;

    // Ratios of 0 and 1 mean the divider is bypassed.
    assign n_measurable = (N_exp[SIZE-1:1] != '0);

    // Saturating increment: the counter parks at all-ones instead of wrapping,
    // so a missing edge is reported as a timeout rather than a bogus short
    // period.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_ONES) ? c : c + 1'b1;
    endfunction

    // A measurement matches when the period equals the ratio and the high
    // phase is either floor(n/2) or ceil(n/2), so odd ratios may put the
    // extra cycle in either phase.
    function automatic logic calc_mismatch(
        input logic [CNT_W-1:0] period,
        input logic [CNT_W-1:0] high,
        input logic [SIZE-1:0]  n
    );
        logic [CMP_W-1:0] p_x;
        logic [CMP_W-1:0] h_x;
        logic [CMP_W-1:0] n_x;
        logic [CMP_W-1:0] half_lo;
        logic [CMP_W-1:0] half_hi;
        p_x     = CMP_W'(period);
        h_x     = CMP_W'(high);
        n_x     = CMP_W'(n);
        half_lo = n_x >> 1;
        half_hi = (n_x + CMP_W'(1)) >> 1;
        return (p_x != n_x) || ((h_x != half_lo) && (h_x != half_hi));
    endfunction

    // NOTE: every register here is written with <= so that all of them update
    // from the same pre-edge values; the s1 -> s2 -> q chain only behaves as a
    // shift register because of this.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            s1          <= 1'b0;
            s2          <= 1'b0;
            q           <= 1'b0;
            cnt         <= '0;
            high_cap    <= '0;
            n_lat       <= '0;
            meas_valid  <= 1'b0;
            meas_period <= '0;
            meas_high   <= '0;
            mismatch    <= 1'b0;
            timeout     <= 1'b0;
            bypass      <= 1'b0;
        end else begin
            // Two-flop synchroniser followed by the edge-history flop.
            s1 <= mon_in;
            s2 <= s1;
            q  <= s2;

            // bypass is only ever raised from IDLE.
            bypass <= 1'b0;

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (enable && n_measurable) begin
                        n_lat <= N_exp;
                        state <= S_ARM;
                    end else begin
                        bypass <= enable;
                    end
                end

                // Waiting for a fresh rising edge; anything seen before arming
                // is ignored so the first period is always complete.
                S_ARM: begin
                    if (!enable) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (rise) begin
                        cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                        state <= S_HIGH;
                    end else if (cnt == CNT_ONES) begin
                        meas_period <= CNT_ONES;
                        meas_high   <= '0;
                        timeout     <= 1'b1;
                        mismatch    <= 1'b1;
                        meas_valid  <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt_inc(cnt);
                    end
                end

                // cnt started at 1 on the rise, so on the falling edge it
                // already equals the number of high cycles.
                S_HIGH: begin
                    if (!enable) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (fall) begin
                        high_cap <= cnt;
                        cnt      <= cnt_inc(cnt);
                        state    <= S_LOW;
                    end else if (cnt == CNT_ONES) begin
                        meas_period <= CNT_ONES;
                        meas_high   <= '0;
                        timeout     <= 1'b1;
                        mismatch    <= 1'b1;
                        meas_valid  <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt_inc(cnt);
                    end
                end

                S_LOW: begin
                    if (!enable) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (rise) begin
                        meas_period <= cnt;
                        meas_high   <= high_cap;
                        mismatch    <= calc_mismatch(cnt, high_cap, n_lat);
                        timeout     <= 1'b0;
                        meas_valid  <= 1'b1;
                        state       <= S_DONE;
                    end else if (cnt == CNT_ONES) begin
                        meas_period <= CNT_ONES;
                        meas_high   <= high_cap;
                        timeout     <= 1'b1;
                        mismatch    <= 1'b1;
                        meas_valid  <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt_inc(cnt);
                    end
                end

                // Result frozen until acknowledged; enable=0 here does not
                // discard it. A ratio that became unmeasurable while the
                // result was held is reported via bypass from IDLE.
                S_DONE: begin
                    if (meas_ack) begin
                        meas_valid <= 1'b0;
                        timeout    <= 1'b0;
                        mismatch   <= 1'b0;
                        cnt        <= '0;
                        if (enable && n_measurable) begin
                            n_lat <= N_exp;
                            state <= S_ARM;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/clock_div_mon.md
CLOCK_DIV_MON -- requirements
Module: clock_div_mon

Interface
REQ-001 Parameter SIZE, default 3: width of the expected divide value, matching the clock divider's N width.
REQ-002 Parameter CNT_W, default 8: width of the measurement counters and results.
REQ-003 Single clock and reset: clk is the only clock; reset_n is asynchronous and active-low.
REQ-004 clk  input  1  sampling clock (the divider's source clock).
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 mon_in  input  1  divided clock under test, asynchronous to the sampling logic, never used as a clock.
REQ-007 N_exp  input  SIZE  expected divide ratio; latched at arm time.
REQ-008 enable  input  1  level: 1 runs measurements, 0 aborts and idles.
REQ-009 meas_ack  input  1  consumer acknowledge; sampled only while meas_valid=1.
REQ-010 meas_valid  output  1  result registers valid; held until acknowledged.
REQ-011 meas_period  output  CNT_W  clk cycles between successive mon_in rising edges.
REQ-012 meas_high  output  CNT_W  clk cycles from rising to falling edge.
REQ-013 mismatch  output  1  result disagrees with the latched N_exp.
REQ-014 timeout  output  1  no edge seen within the counter range.
REQ-015 bypass  output  1  N_exp in {0,1}; the divider passes clk through, which cannot be measured.

Function
REQ-016 Input conditioning: mon_in passes through 2 synchronizer flops (s1, s2) and a history flop q.
- rise = s2 & ~q
- fall = ~s2 & q
REQ-017 The FSM SHALL have states IDLE, ARM, HIGH, LOW and DONE, with a CNT_W counter cnt that saturates at all-ones.
REQ-018 IDLE:
- enable=1 and N_exp[SIZE-1:1]!=0: latch n_lat=N_exp, set cnt=0, go to ARM.
- enable=1 and N_exp<2: stay in IDLE with bypass=1.
- bypass=0 whenever enable=0 or N_exp>=2.
REQ-019 ARM: cnt increments each cycle; on rise, cnt=1 and go to HIGH.
REQ-020 HIGH: cnt increments each cycle; on fall, capture high_cap=cnt and go to LOW.
REQ-021 LOW: cnt increments each cycle; on rise, load the result and go to DONE:
- meas_period=cnt
- meas_high=high_cap
- meas_valid=1
REQ-022 Mismatch, computed at load: mismatch=1 if meas_period!=n_lat, or meas_high is not floor(n_lat/2) or ceil(n_lat/2).
REQ-023 Timeout: in ARM, HIGH or LOW, when cnt==all-ones with no qualifying edge, go to DONE with:
- meas_period=all-ones
- meas_high=high_cap, or 0 if the timeout occurred in ARM or HIGH
- timeout=1, mismatch=1, meas_valid=1
REQ-024 DONE:
- Outputs are frozen and further mon_in edges are ignored.
- meas_ack=1 clears meas_valid, timeout and mismatch on the next edge.
- Then go to ARM (cnt=0, n_lat relatched) if enable=1, else to IDLE.
REQ-025 enable=0 in ARM, HIGH or LOW aborts to IDLE on the next edge: no result, cnt=0. enable=0 in DONE does not clear meas_valid.
REQ-026 meas_ack while meas_valid=0 is ignored.
REQ-027 Latency: meas_valid rises on the clk edge that detects the second rise (2-3 clk after the physical mon_in edge).
REQ-028 N_exp changes after arm have no effect until the next arm.

Reset
REQ-029 reset_n=0 immediately forces:
- FSM to IDLE
- s1, s2, q, cnt, high_cap, n_lat to 0
- all outputs to 0
REQ-030 Reset mid-measurement discards the partial result.
REQ-031 The first measurement after reset starts only from a fresh rise seen in ARM.

Verification
REQ-032 N_exp=4, mon_in=clk/4 (50% duty), enable=1 -> meas_valid=1, meas_period=4, meas_high=2, mismatch=0, timeout=0.
REQ-033 N_exp=5, mon_in=clk/5 with a 3-high/2-low pattern -> period=5, high=3, mismatch=0; repeated with N_exp=6 -> mismatch=1.
REQ-034 CNT_W=8, N_exp=2, mon_in stuck at 0 -> meas_valid=1, timeout=1, meas_period=8'hFF, meas_high=0, mismatch=1.
REQ-035 Valid result held 20 cycles with no ack while mon_in keeps toggling -> outputs unchanged; ack -> meas_valid=0 next cycle, next result follows.
REQ-036 enable deasserted during HIGH -> no meas_valid, FSM in IDLE; reset_n pulsed during LOW -> all outputs 0 asynchronously.
REQ-037 N_exp=1, enable=1 -> bypass=1, meas_valid stays 0 indefinitely.
